// File: rtl/mod_inv_pkg.sv
// mod_inv_pkg: field constants, FSM state type and index width shared by the
// modular inverter and its multiplier.
package mod_inv_pkg;

  localparam int V  = 16;
  localparam int W  = 2 * V;
  localparam int IW = $clog2(W);

  // Solinas prime 2^32 - 2^13 - 2^12 + 1
  localparam logic [W-1:0] Q = 32'd4294955009;
  // Fermat exponent Q-2 (32'hFFFFCFFF)
  localparam logic [W-1:0] E = Q - 32'd2;

  // First exponent bit processed; the MSB is absorbed by acc = base.
  localparam logic [IW-1:0] IDX_START = IW'(W - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SQR  = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mod_inv_mul.sv
// mod_inv_mul: combinational W x W -> W multiplier mod Q.
// Semi-Karatsuba 64-bit product, two Solinas folds using
// 2^32 == 2^13 + 2^12 - 1 (mod Q), then one conditional subtract.
module mod_inv_mul
  import mod_inv_pkg::*;
(
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_p
);

  logic [V-1:0]   w_a0, w_a1, w_b0, w_b1;
  logic [2*V-1:0] w_ll, w_hh;
  logic [V:0]     w_as, w_bs;
  logic [2*V+1:0] w_ss;
  logic [2*V:0]   w_mid;
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_h1, w_l1;
  logic [W+15:0]  w_t1;
  logic [15:0]    w_h2;
  logic [W-1:0]   w_l2;
  logic [W+1:0]   w_t2;

  assign w_a0 = i_a[V-1:0];
  assign w_a1 = i_a[W-1:V];
  assign w_b0 = i_b[V-1:0];
  assign w_b1 = i_b[W-1:V];

  // Three half-width products; the cross term comes from the sum product.
  assign w_ll  = {16'b0, w_a0} * {16'b0, w_b0};
  assign w_hh  = {16'b0, w_a1} * {16'b0, w_b1};
  assign w_as  = {1'b0, w_a0} + {1'b0, w_a1};
  assign w_bs  = {1'b0, w_b0} + {1'b0, w_b1};
  assign w_ss  = {17'b0, w_as} * {17'b0, w_bs};
  assign w_mid = 33'(w_ss - {2'b0, w_hh} - {2'b0, w_ll});

  // hh and ll do not overlap, so they concatenate; mid lands at bit 16.
  assign w_prod = {w_hh, w_ll} + {15'b0, w_mid, 16'b0};

  // First fold: H*2^32 + L -> H*(2^13 + 2^12 - 1) + L, below 2^47.
  assign w_h1 = w_prod[2*W-1:W];
  assign w_l1 = w_prod[W-1:0];
  assign w_t1 = {3'b0, w_h1, 13'b0} + {4'b0, w_h1, 12'b0}
              - {16'b0, w_h1} + {16'b0, w_l1};

  // Second fold: high part is at most 2^14 + 1, result stays below 2Q.
  assign w_h2 = w_t1[W+15:W];
  assign w_l2 = w_t1[W-1:0];
  assign w_t2 = {5'b0, w_h2, 13'b0} + {6'b0, w_h2, 12'b0}
              - {18'b0, w_h2} + {2'b0, w_l2};

  // Final conditional subtract brings the value into [0, Q).
  always_comb begin
    if (w_t2 >= {2'b0, Q}) o_p = W'(w_t2 - {2'b0, Q});
    else                   o_p = W'(w_t2);
  end

endmodule

// File: rtl/mod_inv.sv
// mod_inv: sequential inverter a^(Q-2) mod Q using left-to-right
// square-and-multiply over one shared mod_inv_mul instance.
// Optional macro MOD_INV_EARLY_ZERO_EN: a zero reduced operand skips the
// exponentiation and goes straight to DONE (otherwise latency is constant).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE; the source holds in_a and
// in_valid until the transfer. out_valid/out_inv/out_err are held stable in
// DONE until out_ready is seen high.
module mod_inv
  import mod_inv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_inv,
  output logic         out_err,
  output state_t       dbg_state
);

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_base;
  logic [IW-1:0] r_idx;
  logic          r_zero;
  logic [W-1:0]  w_red;
  logic [W-1:0]  w_mul_b;
  logic [W-1:0]  w_mul_p;

  // Single conditional subtract is enough since in_a < 2Q.
  assign w_red = (in_a >= Q) ? (in_a - Q) : in_a;

  // Square uses acc twice, multiply uses acc and the stored base.
  assign w_mul_b = (r_state == ST_MUL) ? r_base : r_acc;

  mod_inv_mul u_mul (
    .i_a (r_acc),
    .i_b (w_mul_b),
    .o_p (w_mul_p)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic following the exponent bit pattern.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef MOD_INV_EARLY_ZERO_EN
          if (w_red == '0) w_next = ST_DONE;
          else             w_next = ST_SQR;
`else
          w_next = ST_SQR;
`endif
        end
      end
      ST_SQR: begin
        if (E[r_idx])           w_next = ST_MUL;
        else if (r_idx == '0)   w_next = ST_DONE;
        else                    w_next = ST_SQR;
      end
      ST_MUL: begin
        if (r_idx == '0) w_next = ST_DONE;
        else             w_next = ST_SQR;
      end
      ST_DONE: begin
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand capture, accumulator update and exponent index walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_base <= '0;
      r_idx  <= '0;
      r_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_base <= w_red;
            r_acc  <= w_red;
            r_idx  <= IDX_START;
            r_zero <= (w_red == '0);
          end
        end
        ST_SQR: begin
          r_acc <= w_mul_p;
          if (!E[r_idx]) r_idx <= r_idx - 1'b1;
        end
        ST_MUL: begin
          r_acc <= w_mul_p;
          r_idx <= r_idx - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out_inv   = r_acc;
  assign out_err   = r_zero;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mod_inv.sv
// tb_mod_inv: randomized and directed bench for mod_inv, checked against a
// plain-arithmetic Fermat-inverse model with an expected-result queue.
module tb_mod_inv;
  import mod_inv_pkg::*;

  localparam logic [31:0] QM  = 32'd4294955009;
  localparam logic [63:0] QM64 = 64'd4294955009;
  localparam int N_RAND = 500;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_a = '0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_inv;
  logic        out_err;
  state_t      dbg_state;

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  mod_inv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inv   (out_inv),
    .out_err   (out_err),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic        err_q[$];
  logic [31:0] red_q[$];
  int          acc_q[$];
  int          lat_q[$];
  int total = 0;
  int bad = 0;
  int last_hs = 0;
  int last_acc = 0;
  bit hold_stall = 1'b0;
  bit rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] f_red(input logic [31:0] a);
    return (a >= QM) ? a - QM : a;
  endfunction

  function automatic logic [31:0] f_pow(input logic [31:0] b, input logic [31:0] e);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 31; i >= 0; i--) begin
      r = (r * r) % QM64;
      if (e[i]) r = (r * {32'b0, b}) % QM64;
    end
    return r[31:0];
  endfunction

  function automatic logic [31:0] f_inv(input logic [31:0] a_red);
    if (a_red == 0) return 32'd0;
    return f_pow(a_red, QM - 32'd2);
  endfunction

  function automatic int f_lat(input logic err);
`ifdef MOD_INV_EARLY_ZERO_EN
    return err ? 1 : 60;
`else
    return (err === 1'bx) ? 0 : 60;
`endif
  endfunction

  task automatic flush_q();
    exp_q.delete(); err_q.delete(); red_q.delete(); acc_q.delete(); lat_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] e_inv, input logic e_err);
    int n;
    n = 0;
    @(posedge clk); #2;
    in_valid = 1'b1;
    in_a = a;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e_inv);
    err_q.push_back(e_err);
    red_q.push_back(f_red(a));
    acc_q.push_back(cycle + 1);
    lat_q.push_back(f_lat(e_err));
    last_acc = cycle + 1;
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'd0, 64'd1);
      flush_q();
    end
  endtask

  // Result consumer: ready always, randomly, or held off.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (hold_stall)      out_ready = 1'b0;
      else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      else                 out_ready = 1'b1;
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (exp_q.size() == 0) begin
          chk("idle_no_valid", {63'b0, out_valid}, 64'd0);
        end else if (cycle < acc_q[0] + lat_q[0]) begin
          chk("busy_no_valid", {63'b0, out_valid}, 64'd0);
        end else begin
          chk("out_valid", {63'b0, out_valid}, 64'd1);
          chk("out_inv", {32'b0, out_inv}, {32'b0, exp_q[0]});
          chk("out_err", {63'b0, out_err}, {63'b0, err_q[0]});
          chk("done_in_ready", {63'b0, in_ready}, 64'd0);
          if (!err_q[0])
            chk("inv_product", ({32'b0, red_q[0]} * {32'b0, out_inv}) % QM64, 64'd1);
          if (out_valid && out_ready) begin
            last_hs = cycle + 1;
            void'(exp_q.pop_front());
            void'(err_q.pop_front());
            void'(red_q.pop_front());
            void'(acc_q.pop_front());
            void'(lat_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] ar;
    int r;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset_out_inv", {32'b0, out_inv}, 64'd0);
    chk("reset_out_err", {63'b0, out_err}, 64'd0);
    chk("reset_state", {62'b0, dbg_state}, {62'b0, ST_IDLE});

    // Model pins against hand-computed values.
    chk("model_inv1", {32'b0, f_inv(32'd1)}, 64'd1);
    chk("model_inv2", {32'b0, f_inv(32'd2)}, 64'd2147477505);
    chk("model_inv3", {32'b0, f_inv(32'd3)}, 64'd1431651670);
    chk("model_invqm1", {32'b0, f_inv(QM - 32'd1)}, 64'd4294955008);

    // Directed operands with literal expectations.
    send(32'd1, 32'd1, 1'b0);
    send(32'd2, 32'd2147477505, 1'b0);
    send(32'd4294955008, 32'd4294955008, 1'b0);
    send(32'd0, 32'd0, 1'b1);
    send(32'd4294955009, 32'd0, 1'b1);
    send(32'd4294955011, 32'd2147477505, 1'b0);
    wait_drain();

    // Result stalled 20 cycles; a new operand waits until IDLE.
    hold_stall = 1'b1;
    send(32'd7, f_inv(32'd7), 1'b0);
    r = 0;
    while (!out_valid && r < 200) begin
      @(negedge clk);
      r++;
    end
    chk("stall_reached_done", {63'b0, out_valid}, 64'd1);
    @(posedge clk); #2;
    in_valid = 1'b1;
    in_a = 32'd9;
    repeat (20) begin
      @(negedge clk);
      chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
      chk("stall_valid", {63'b0, out_valid}, 64'd1);
    end
    hold_stall = 1'b0;
    send(32'd9, f_inv(32'd9), 1'b0);
    chk("accept_after_idle", last_acc, last_hs + 1);
    wait_drain();

    // Reset in the middle of an operation discards it.
    send(32'd5, f_inv(32'd5), 1'b0);
    while (cycle < last_acc + 30) @(negedge clk);
    rst_n = 1'b0;
    flush_q();
    repeat (2) @(negedge clk);
    chk("midreset_out_valid", {63'b0, out_valid}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_in_ready", {63'b0, in_ready}, 64'd1);
    chk("midreset_out_inv", {32'b0, out_inv}, 64'd0);
    repeat (70) @(negedge clk);
    send(32'd3, 32'd1431651670, 1'b0);
    wait_drain();

    // Random operands including zero, Q and the wrap region above Q.
    rand_ready = 1'b1;
    for (int i = 0; i < N_RAND; i++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      a = 32'd0;
      else if (r == 1) a = QM;
      else if (r == 2) a = QM + $urandom_range(0, 12286);
      else             a = $urandom;
      ar = f_red(a);
      send(a, f_inv(ar), (ar == 32'd0));
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
